// File: rtl/axil_timer_pkg.sv
// Shared constants for the AXI-Lite timer: register offsets, CTRL bit indices,
// response codes and a byte-strobe merge helper.
package axil_timer_pkg;

  localparam logic [7:0] REG_CTRL     = 8'h00;
  localparam logic [7:0] REG_STATUS   = 8'h04;
  localparam logic [7:0] REG_LOAD     = 8'h08;
  localparam logic [7:0] REG_COUNT    = 8'h0C;
  localparam logic [7:0] REG_PRESCALE = 8'h10;
  localparam logic [7:0] REG_CYCLE_LO = 8'h14;
  localparam logic [7:0] REG_CYCLE_HI = 8'h18;

  localparam int unsigned CTRL_EN          = 0;
  localparam int unsigned CTRL_AUTO_RELOAD = 1;
  localparam int unsigned CTRL_IRQ_EN      = 2;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  function automatic logic [31:0] apply_strb(input logic [31:0] old_val,
                                             input logic [31:0] wdata,
                                             input logic [3:0]  strb);
    logic [31:0] res;
    res = old_val;
    for (int unsigned i = 0; i < 4; i++) begin
      if (strb[i]) res[8*i +: 8] = wdata[8*i +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/axil_timer_irq_slave_if.sv
// Generic AXI-Lite slave front end: captures AW/W independently, performs one
// register write per transaction, and returns registered read data.
module axil_slave_if
  import axil_timer_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int STRB_WIDTH = DATA_WIDTH/8
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic [ADDR_WIDTH-1:0] awaddr_i,
  input  logic                  awvalid_i,
  output logic                  awready_o,
  input  logic [DATA_WIDTH-1:0] wdata_i,
  input  logic [STRB_WIDTH-1:0] wstrb_i,
  input  logic                  wvalid_i,
  output logic                  wready_o,
  output logic [1:0]            bresp_o,
  output logic                  bvalid_o,
  input  logic                  bready_i,
  input  logic [ADDR_WIDTH-1:0] araddr_i,
  input  logic                  arvalid_i,
  output logic                  arready_o,
  output logic [DATA_WIDTH-1:0] rdata_o,
  output logic [1:0]            rresp_o,
  output logic                  rvalid_o,
  input  logic                  rready_i,
  output logic                  reg_wr_en_o,
  output logic [ADDR_WIDTH-1:0] reg_wr_addr_o,
  output logic [DATA_WIDTH-1:0] reg_wr_data_o,
  output logic [STRB_WIDTH-1:0] reg_wr_strb_o,
  input  logic                  reg_wr_err_i,
  output logic                  reg_rd_en_o,
  output logic [ADDR_WIDTH-1:0] reg_rd_addr_o,
  input  logic [DATA_WIDTH-1:0] reg_rd_data_i,
  input  logic                  reg_rd_err_i
);

  logic                  live_q;
  logic                  aw_held_q, w_held_q;
  logic [ADDR_WIDTH-1:0] awaddr_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic [STRB_WIDTH-1:0] wstrb_q;
  logic                  bvalid_q, rvalid_q;
  logic [1:0]            bresp_q, rresp_q;
  logic [DATA_WIDTH-1:0] rdata_q;

  // live_q keeps every ready low while reset is asserted and for the first edge after
  assign awready_o = live_q && !aw_held_q && !bvalid_q;
  assign wready_o  = live_q && !w_held_q && !bvalid_q;
  assign arready_o = live_q && !rvalid_q;

  assign bvalid_o = bvalid_q;
  assign bresp_o  = bresp_q;
  assign rvalid_o = rvalid_q;
  assign rresp_o  = rresp_q;
  assign rdata_o  = rdata_q;

  assign reg_wr_en_o   = aw_held_q && w_held_q && !bvalid_q;
  assign reg_wr_addr_o = awaddr_q;
  assign reg_wr_data_o = wdata_q;
  assign reg_wr_strb_o = wstrb_q;

  assign reg_rd_en_o   = arvalid_i && arready_o;
  assign reg_rd_addr_o = araddr_i;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      live_q    <= 1'b0;
      aw_held_q <= 1'b0;
      w_held_q  <= 1'b0;
      awaddr_q  <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      bvalid_q  <= 1'b0;
      bresp_q   <= RESP_OKAY;
      rvalid_q  <= 1'b0;
      rresp_q   <= RESP_OKAY;
      rdata_q   <= '0;
    end else begin
      live_q <= 1'b1;
      if (awvalid_i && awready_o) begin
        aw_held_q <= 1'b1;
        awaddr_q  <= awaddr_i;
      end
      if (wvalid_i && wready_o) begin
        w_held_q <= 1'b1;
        wdata_q  <= wdata_i;
        wstrb_q  <= wstrb_i;
      end
      if (reg_wr_en_o) begin
        bvalid_q <= 1'b1;
        bresp_q  <= reg_wr_err_i ? RESP_SLVERR : RESP_OKAY;
      end
      if (bvalid_q && bready_i) begin
        bvalid_q  <= 1'b0;
        aw_held_q <= 1'b0;
        w_held_q  <= 1'b0;
      end
      if (reg_rd_en_o) begin
        rvalid_q <= 1'b1;
        rdata_q  <= reg_rd_data_i;
        rresp_q  <= reg_rd_err_i ? RESP_SLVERR : RESP_OKAY;
      end else if (rvalid_q && rready_i) begin
        rvalid_q <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/axil_timer_irq.sv
// AXI-Lite timer: prescaled 32-bit down-counter with reload/one-shot, 64-bit
// free-running cycle counter with HI snapshot, and a registered level irq.
module axil_timer_irq
  import axil_timer_pkg::*;
#(
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int STRB_WIDTH     = DATA_WIDTH/8,
  parameter int PRESCALE_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_WIDTH-1:0] s_axil_awaddr,
  input  logic [2:0]            s_axil_awprot,
  input  logic                  s_axil_awvalid,
  output logic                  s_axil_awready,
  input  logic [DATA_WIDTH-1:0] s_axil_wdata,
  input  logic [STRB_WIDTH-1:0] s_axil_wstrb,
  input  logic                  s_axil_wvalid,
  output logic                  s_axil_wready,
  output logic [1:0]            s_axil_bresp,
  output logic                  s_axil_bvalid,
  input  logic                  s_axil_bready,
  input  logic [ADDR_WIDTH-1:0] s_axil_araddr,
  input  logic [2:0]            s_axil_arprot,
  input  logic                  s_axil_arvalid,
  output logic                  s_axil_arready,
  output logic [DATA_WIDTH-1:0] s_axil_rdata,
  output logic [1:0]            s_axil_rresp,
  output logic                  s_axil_rvalid,
  input  logic                  s_axil_rready,
  output logic                  irq
);

  logic                  reg_wr_en, reg_wr_err, reg_rd_en, reg_rd_err;
  logic [ADDR_WIDTH-1:0] reg_wr_addr, reg_rd_addr;
  logic [DATA_WIDTH-1:0] reg_wr_data, reg_rd_data;
  logic [STRB_WIDTH-1:0] reg_wr_strb;

  axil_slave_if #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .DATA_WIDTH (DATA_WIDTH),
    .STRB_WIDTH (STRB_WIDTH)
  ) u_if (
    .clk_i         (clk),
    .rst_i         (rst),
    .awaddr_i      (s_axil_awaddr),
    .awvalid_i     (s_axil_awvalid),
    .awready_o     (s_axil_awready),
    .wdata_i       (s_axil_wdata),
    .wstrb_i       (s_axil_wstrb),
    .wvalid_i      (s_axil_wvalid),
    .wready_o      (s_axil_wready),
    .bresp_o       (s_axil_bresp),
    .bvalid_o      (s_axil_bvalid),
    .bready_i      (s_axil_bready),
    .araddr_i      (s_axil_araddr),
    .arvalid_i     (s_axil_arvalid),
    .arready_o     (s_axil_arready),
    .rdata_o       (s_axil_rdata),
    .rresp_o       (s_axil_rresp),
    .rvalid_o      (s_axil_rvalid),
    .rready_i      (s_axil_rready),
    .reg_wr_en_o   (reg_wr_en),
    .reg_wr_addr_o (reg_wr_addr),
    .reg_wr_data_o (reg_wr_data),
    .reg_wr_strb_o (reg_wr_strb),
    .reg_wr_err_i  (reg_wr_err),
    .reg_rd_en_o   (reg_rd_en),
    .reg_rd_addr_o (reg_rd_addr),
    .reg_rd_data_i (reg_rd_data),
    .reg_rd_err_i  (reg_rd_err)
  );

  logic [2:0]                ctrl_q, ctrl_d;
  logic                      pending_q, pending_d;
  logic [31:0]               load_q, load_d, count_q, count_d;
  logic [PRESCALE_WIDTH-1:0] prescale_q, prescale_d, psc_q, psc_d;
  logic [63:0]               cycle_q;
  logic [31:0]               hi_snap_q, hi_snap_d;
  logic                      irq_q;
  logic                      tick, expire;
  logic [7:0]                wr_off, rd_off;
  logic [31:0]               wr_old, wr_val;

  assign wr_off     = {reg_wr_addr[7:2], 2'b00};
  assign rd_off     = {reg_rd_addr[7:2], 2'b00};
  assign reg_wr_err = (wr_off > REG_CYCLE_HI);
  assign irq        = irq_q;

  logic unused_ok;
  assign unused_ok = ^{s_axil_awprot, s_axil_arprot,
                       reg_wr_addr[ADDR_WIDTH-1:8], reg_wr_addr[1:0],
                       reg_rd_addr[ADDR_WIDTH-1:8], reg_rd_addr[1:0]};

  always_comb begin
    case (wr_off)
      REG_CTRL:     wr_old = {29'd0, ctrl_q};
      REG_LOAD:     wr_old = load_q;
      REG_COUNT:    wr_old = count_q;
      REG_PRESCALE: wr_old = 32'(prescale_q);
      default:      wr_old = '0;
    endcase
    wr_val = apply_strb(wr_old, reg_wr_data, reg_wr_strb);
  end

  always_comb begin
    reg_rd_data = '0;
    reg_rd_err  = 1'b0;
    hi_snap_d   = hi_snap_q;
    case (rd_off)
      REG_CTRL:     reg_rd_data = {29'd0, ctrl_q};
      REG_STATUS:   reg_rd_data = {31'd0, pending_q};
      REG_LOAD:     reg_rd_data = load_q;
      REG_COUNT:    reg_rd_data = count_q;
      REG_PRESCALE: reg_rd_data = 32'(prescale_q);
      REG_CYCLE_LO: begin
        reg_rd_data = cycle_q[31:0];
        if (reg_rd_en) hi_snap_d = cycle_q[63:32];
      end
      REG_CYCLE_HI: reg_rd_data = hi_snap_q;
      default:      reg_rd_err  = 1'b1;
    endcase
  end

  // Timer update first, then software writes override it; only pending's
  // set-on-expiry beats a same-cycle W1C.
  always_comb begin
    tick       = ctrl_q[CTRL_EN] && (psc_q == prescale_q);
    expire     = tick && (count_q == '0);
    ctrl_d     = ctrl_q;
    pending_d  = pending_q;
    load_d     = load_q;
    count_d    = count_q;
    prescale_d = prescale_q;
    psc_d      = psc_q;
    if (ctrl_q[CTRL_EN]) psc_d = tick ? '0 : psc_q + PRESCALE_WIDTH'(1);
    if (tick) begin
      if (!expire) begin
        count_d = count_q - 32'd1;
      end else begin
        pending_d = 1'b1;
        if (ctrl_q[CTRL_AUTO_RELOAD]) count_d = load_q;
        else                          ctrl_d[CTRL_EN] = 1'b0;
      end
    end
    if (reg_wr_en) begin
      case (wr_off)
        REG_CTRL: begin
          ctrl_d = wr_val[2:0];
          if (!ctrl_q[CTRL_EN] && wr_val[CTRL_EN]) psc_d = '0;
        end
        REG_STATUS:   if (reg_wr_strb[0] && reg_wr_data[0] && !expire) pending_d = 1'b0;
        REG_LOAD:     load_d     = wr_val;
        REG_COUNT:    count_d    = wr_val;
        REG_PRESCALE: prescale_d = wr_val[PRESCALE_WIDTH-1:0];
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ctrl_q     <= '0;
      pending_q  <= 1'b0;
      load_q     <= '0;
      count_q    <= '0;
      prescale_q <= '0;
      psc_q      <= '0;
      cycle_q    <= '0;
      hi_snap_q  <= '0;
      irq_q      <= 1'b0;
    end else begin
      ctrl_q     <= ctrl_d;
      pending_q  <= pending_d;
      load_q     <= load_d;
      count_q    <= count_d;
      prescale_q <= prescale_d;
      psc_q      <= psc_d;
      cycle_q    <= cycle_q + 64'd1;
      hi_snap_q  <= hi_snap_d;
      irq_q      <= pending_q && ctrl_q[CTRL_IRQ_EN];
    end
  end

endmodule

// File: tb/tb_axil_timer_irq.sv
// Directed self-checking bench for axil_timer_irq.
module tb_axil_timer_irq;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] awaddr = '0, araddr = '0, wdata = '0;
  logic [2:0]  awprot = '0, arprot = '0;
  logic        awvalid = 1'b0, wvalid = 1'b0, bready = 1'b0, arvalid = 1'b0, rready = 1'b0;
  logic [3:0]  wstrb = '0;
  logic        awready, wready, bvalid, arready, rvalid, irq;
  logic [1:0]  bresp, rresp;
  logic [31:0] rdata;

  int tests = 0;
  int fails = 0;
  logic [63:0] tb_cyc;
  logic [63:0] rd_cyc;

  axil_timer_irq #(
    .ADDR_WIDTH     (32),
    .DATA_WIDTH     (32),
    .STRB_WIDTH     (4),
    .PRESCALE_WIDTH (16)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .s_axil_awaddr  (awaddr),
    .s_axil_awprot  (awprot),
    .s_axil_awvalid (awvalid),
    .s_axil_awready (awready),
    .s_axil_wdata   (wdata),
    .s_axil_wstrb   (wstrb),
    .s_axil_wvalid  (wvalid),
    .s_axil_wready  (wready),
    .s_axil_bresp   (bresp),
    .s_axil_bvalid  (bvalid),
    .s_axil_bready  (bready),
    .s_axil_araddr  (araddr),
    .s_axil_arprot  (arprot),
    .s_axil_arvalid (arvalid),
    .s_axil_arready (arready),
    .s_axil_rdata   (rdata),
    .s_axil_rresp   (rresp),
    .s_axil_rvalid  (rvalid),
    .s_axil_rready  (rready),
    .irq            (irq)
  );

  always #5 clk = ~clk;

  always @(posedge clk or posedge rst) begin
    if (rst) tb_cyc <= '0;
    else     tb_cyc <= tb_cyc + 64'd1;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic axi_read(input logic [31:0] a, output logic [31:0] d, output logic [1:0] r);
    int n = 0;
    @(negedge clk);
    araddr = a; arvalid = 1'b1;
    while (!arready && n < 20) begin @(negedge clk); n++; end
    check("arready", arready, 1);
    rd_cyc = tb_cyc;
    @(posedge clk); #1;
    arvalid = 1'b0;
    check("rvalid_1cyc", rvalid, 1);
    d = rdata; r = rresp;
    rready = 1'b1;
    @(posedge clk); #1;
    rready = 1'b0;
    check("rvalid_clr", rvalid, 0);
  endtask

  task automatic axi_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                           output logic [1:0] r);
    int n = 0;
    @(negedge clk);
    awaddr = a; wdata = d; wstrb = s; awvalid = 1'b1; wvalid = 1'b1;
    while (!(awready && wready) && n < 20) begin @(negedge clk); n++; end
    check("aw_w_ready", {awready, wready}, 2'b11);
    @(posedge clk); #1;
    awvalid = 1'b0; wvalid = 1'b0;
    check("bvalid_early", bvalid, 0);
    @(posedge clk); #1;
    check("bvalid", bvalid, 1);
    r = bresp; bready = 1'b1;
    @(posedge clk); #1;
    bready = 1'b0;
    check("bvalid_clr", bvalid, 0);
  endtask

  task automatic wr_ok(input logic [31:0] a, input logic [31:0] d);
    logic [1:0] r;
    axi_write(a, d, 4'hF, r);
    check("bresp_ok", r, 2'b00);
  endtask

  task automatic rd_expect(input string tag, input logic [31:0] a, input logic [31:0] exp);
    logic [31:0] d;
    logic [1:0] r;
    axi_read(a, d, r);
    check(tag, d, exp);
    check("rresp_ok", r, 2'b00);
  endtask

  initial begin
    logic [31:0] d;
    logic [1:0]  r;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_outputs", {awready, wready, arready, bvalid, rvalid, irq}, 6'b0);
    check("rst_resp_data", {bresp, rresp, rdata}, 36'd0);
    @(negedge clk); rst = 1'b0;

    rd_expect("rst_ctrl",     32'h00, 32'h0);
    rd_expect("rst_status",   32'h04, 32'h0);
    rd_expect("rst_load",     32'h08, 32'h0);
    rd_expect("rst_count",    32'h0C, 32'h0);
    rd_expect("rst_prescale", 32'h10, 32'h0);
    axi_read(32'h14, d, r);
    check("rst_cycle_lo", d, rd_cyc[31:0]);
    check("rst_cycle_lo_resp", r, 2'b00);
    rd_expect("rst_cycle_hi", 32'h18, 32'h0);

    // Auto-reload periodic interrupt: PRESCALE=3, COUNT=2 -> expiry every 12 cycles
    wr_ok(32'h10, 32'd3);
    wr_ok(32'h08, 32'd2);
    wr_ok(32'h0C, 32'd2);
    wr_ok(32'h00, 32'h7);
    repeat (11) @(posedge clk);
    #1 check("irq_before_expiry", irq, 0);
    @(posedge clk); #1 check("irq_after_expiry", irq, 1);
    wr_ok(32'h04, 32'h1);
    check("irq_cleared", irq, 0);
    repeat (8) @(posedge clk);
    #1 check("irq_before_reload_expiry", irq, 0);
    @(posedge clk); #1 check("irq_reload_expiry", irq, 1);
    wr_ok(32'h00, 32'h0);
    wr_ok(32'h04, 32'h1);
    rd_expect("status_cleared", 32'h04, 32'h0);

    // One-shot with PRESCALE=0, COUNT=0
    wr_ok(32'h10, 32'd0);
    wr_ok(32'h0C, 32'd0);
    wr_ok(32'h00, 32'h5);
    check("oneshot_irq_lag", irq, 0);
    @(posedge clk); #1 check("oneshot_irq", irq, 1);
    rd_expect("oneshot_ctrl",    32'h00, 32'h4);
    rd_expect("oneshot_count",   32'h0C, 32'h0);
    rd_expect("oneshot_pending", 32'h04, 32'h1);
    wr_ok(32'h04, 32'h1);
    wr_ok(32'h00, 32'h0);

    // W before AW, byte-lane strobe, bready back-pressure
    wr_ok(32'h08, 32'h0);
    @(negedge clk);
    wdata = 32'hAABBCCDD; wstrb = 4'b0010; wvalid = 1'b1;
    @(posedge clk); #1;
    wvalid = 1'b0;
    check("w_held_wready", wready, 0);
    check("w_held_awready", awready, 1);
    repeat (2) @(posedge clk);
    @(negedge clk);
    awaddr = 32'h08; awvalid = 1'b1;
    @(posedge clk); #1;
    awvalid = 1'b0;
    check("split_bvalid_early", bvalid, 0);
    @(posedge clk); #1 check("split_bvalid", bvalid, 1);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      check("bp_hold", {bvalid, awready, wready}, 3'b100);
    end
    check("split_bresp", bresp, 2'b00);
    bready = 1'b1;
    @(posedge clk); #1;
    bready = 1'b0;
    check("split_bvalid_clr", bvalid, 0);
    rd_expect("load_strobed", 32'h08, 32'h0000CC00);

    // Unmapped offsets
    axi_read(32'h20, d, r);
    check("unmapped_rdata", d, 32'h0);
    check("unmapped_rresp", r, 2'b10);
    axi_write(32'h24, 32'hFFFFFFFF, 4'hF, r);
    check("unmapped_bresp", r, 2'b10);
    rd_expect("unmapped_load_kept", 32'h08, 32'h0000CC00);
    rd_expect("unmapped_ctrl_kept", 32'h00, 32'h0);

    // CYCLE_HI returns the snapshot from the CYCLE_LO read, not the carried value
    @(negedge clk);
    force dut.cycle_q = 64'h0000_0000_FFFF_FFFE;
    release dut.cycle_q;
    axi_read(32'h14, d, r);
    check("cycle_lo_at_wrap", d, 32'hFFFFFFFF);
    rd_expect("cycle_hi_snapshot", 32'h18, 32'h0);
    axi_read(32'h14, d, r);
    rd_expect("cycle_hi_after_carry", 32'h18, 32'h1);

    // W1C in the same cycle as one-shot expiry: set wins
    wr_ok(32'h0C, 32'd2);
    wr_ok(32'h00, 32'h1);
    wr_ok(32'h04, 32'h1);
    rd_expect("w1c_vs_expiry", 32'h04, 32'h1);
    rd_expect("w1c_ctrl_oneshot", 32'h00, 32'h0);
    wr_ok(32'h04, 32'h1);
    rd_expect("w1c_plain", 32'h04, 32'h0);

    // Reset in the middle of a write: channels drop, no response afterwards
    @(negedge clk);
    awaddr = 32'h08; awvalid = 1'b1;
    @(posedge clk); #1;
    awvalid = 1'b0;
    check("mid_aw_held", awready, 0);
    #2 rst = 1'b1;
    #1 check("mid_rst_outputs", {awready, wready, arready, bvalid, rvalid, irq}, 6'b0);
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1 check("post_rst_awready", awready, 1);
    @(negedge clk);
    wdata = 32'h12345678; wstrb = 4'hF; wvalid = 1'b1;
    @(posedge clk); #1;
    wvalid = 1'b0;
    repeat (2) @(posedge clk);
    #1 check("post_rst_no_bvalid", bvalid, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not reach the end");
    $fatal(1, "timeout");
  end

endmodule
